// File: rtl/dut_seq_pkg.sv
// -----------------------------------------------------------------------------
// dut_seq_pkg
// Shared definitions for the DUT I/O sequencer: the controller state encoding,
// the unpack-buffer mode constants and a small elaboration-time helper.
// -----------------------------------------------------------------------------
package dut_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        WAIT,
        CAPTURE,
        DRAIN
    } state_t;

    // Unpack buffer mode encodings.
    localparam logic IN_MODE_WRITE    = 1'b1;  // write the input word at addr
    localparam logic OUT_MODE_CAPTURE = 1'b0;  // latch every output lane from the DUT
    localparam logic OUT_MODE_READ    = 1'b1;  // present the output word at addr

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dut_seq_watchdog.sv
// -----------------------------------------------------------------------------
// dut_seq_watchdog
// Counts consecutive WAIT cycles and flags a timeout when the DUT has not
// reported completion within TIMEOUT_CYCLES. The flag is sticky until cleared.
// Only instantiated when DUT_SEQ_TIMEOUT_EN is defined.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   in_wait      in   sequencer is in WAIT this cycle
//   dut_done     in   DUT completion; takes priority over expiry
//   clear        in   accepted start; drops the sticky flag
//   expired      out  combinational: last allowed WAIT cycle passed without dut_done
//   timeout_err  out  sticky timeout flag
// -----------------------------------------------------------------------------
module dut_seq_watchdog
    import dut_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic in_wait,
    input  logic dut_done,
    input  logic clear,
    output logic expired,
    output logic timeout_err
);

    localparam int CW = max_int($clog2(TIMEOUT_CYCLES + 1), 1);

    logic [CW-1:0] wait_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (in_wait) begin
            wait_cnt <= wait_cnt + CW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // wait_cnt holds the number of WAIT cycles already completed, so the
    // TIMEOUT_CYCLES-th WAIT cycle is the one where it equals TIMEOUT_CYCLES-1.
    assign expired = in_wait && !dut_done && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if (clear) begin
            timeout_err <= 1'b0;
        end else if (expired) begin
            timeout_err <= 1'b1;
        end
    end

endmodule

// File: rtl/dut_io_sequencer.sv
// -----------------------------------------------------------------------------
// dut_io_sequencer
// Sequences one DUT transaction through the I/O unpack buffer: loads IN_WORDS
// input words from the AXI side, pulses the DUT, waits for completion, captures
// the output vector and drains OUT_WORDS words back to the AXI side.
//
// Optional feature: define DUT_SEQ_TIMEOUT_EN to add a WAIT watchdog that
// aborts to IDLE after TIMEOUT_CYCLES and raises a sticky timeout_err.
//
// Ports
//   clk, reset               clock; asynchronous active-high reset
//   start                    begin a transaction (sampled in IDLE only)
//   busy / done              not-IDLE level / one-cycle completion pulse
//   in_valid / in_ready      input-word handshake (word goes straight to buffer)
//   out_valid / out_ready    output-word handshake (word read from buffer)
//   dut_input_vec_addr       input word index
//   input_vec_en/_mode       input buffer write strobe / mode
//   dut_output_vec_addr      output word index
//   output_vec_en/_mode      output buffer capture strobe / mode
//   dut_start / dut_done     DUT run pulse / DUT completion
//   timeout_err              sticky watchdog flag (0 without the macro)
// -----------------------------------------------------------------------------
module dut_io_sequencer
    import dut_seq_pkg::*;
#(
    parameter int IN_WORDS       = 8,
    parameter int OUT_WORDS      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] dut_input_vec_addr,
    output logic        input_vec_en,
    output logic        input_vec_mode,
    output logic [31:0] dut_output_vec_addr,
    output logic        output_vec_en,
    output logic        output_vec_mode,
    output logic        dut_start,
    input  logic        dut_done,
    output logic        timeout_err
);

    localparam int CNT_W = $clog2(max_int(IN_WORDS, OUT_WORDS) + 1);
    localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(IN_WORDS - 1);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_WORDS - 1);

    if (IN_WORDS < 1 || OUT_WORDS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("dut_io_sequencer: IN_WORDS, OUT_WORDS and TIMEOUT_CYCLES must be >= 1");
    end

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             done_next;
    logic             wd_expired;

`ifdef DUT_SEQ_TIMEOUT_EN
    logic in_wait;
    logic wd_clear;

    assign in_wait  = (state == WAIT);
    assign wd_clear = (state == IDLE) && start;

    dut_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .reset      (reset),
        .in_wait    (in_wait),
        .dut_done   (dut_done),
        .clear      (wd_clear),
        .expired    (wd_expired),
        .timeout_err(timeout_err)
    );
`else
    assign wd_expired  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            done  <= done_next;
        end
    end

    // Everything except input_vec_en decodes from registered state/counter,
    // so in_valid/out_ready only influence the next state, never these outputs.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can infer a latch.
        state_next          = state;
        cnt_next            = cnt;
        done_next           = 1'b0;
        in_ready            = 1'b0;
        input_vec_mode      = 1'b0;
        dut_input_vec_addr  = '0;
        out_valid           = 1'b0;
        output_vec_en       = 1'b0;
        output_vec_mode     = OUT_MODE_CAPTURE;
        dut_output_vec_addr = '0;
        dut_start           = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    cnt_next   = '0;
                end
            end
            LOAD: begin
                in_ready           = 1'b1;
                input_vec_mode     = IN_MODE_WRITE;
                dut_input_vec_addr = 32'(cnt);
                if (in_valid) begin
                    if (cnt == IN_LAST) begin
                        cnt_next   = '0;
                        state_next = RUN;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            RUN: begin
                dut_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // Completion wins over a watchdog expiry in the same cycle.
                if (dut_done) begin
                    state_next = CAPTURE;
                end else if (wd_expired) begin
                    state_next = IDLE;
                end
            end
            CAPTURE: begin
                output_vec_en   = 1'b1;
                output_vec_mode = OUT_MODE_CAPTURE;
                state_next      = DRAIN;
            end
            DRAIN: begin
                out_valid           = 1'b1;
                output_vec_mode     = OUT_MODE_READ;
                dut_output_vec_addr = 32'(cnt);
                if (out_ready) begin
                    if (cnt == OUT_LAST) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign input_vec_en = in_ready & in_valid;
    assign busy         = (state != IDLE);

endmodule
